formula_cex_enumerator: RTL

- Sequential driver/reader for the combinational `formula` checkers generated by our flow.
- Drives a formula instance's `v_*` inputs and samples its single output `o_1`.
- Enumerates every assignment of a selected subset of inputs, with the other inputs held at fixed values.
- Stops at the first assignment where the formula output is 0 and reports it as a counterexample. Otherwise it reports that the formula holds over the whole subspace.

---
 rtl/formula_cex_enumerator.sv | 130 +++++++++++++
 1 files changed

// File: rtl/formula_cex_enumerator.sv
// Sequential driver for a combinational formula checker: enumerates all assignments
// of the selected free inputs and stops at the first one where the formula evaluates to 0.
module formula_cex_enumerator #(
    parameter int unsigned N_IN  = 49,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [N_IN-1:0]  fixed_val,
    input  logic [N_IN-1:0]  free_mask,
    output logic [N_IN-1:0]  formula_in,
    input  logic             formula_out,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic             aborted,
    output logic [N_IN-1:0]  cex,
    output logic [CNT_W-1:0] iters
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [N_IN-1:0]  r_mask;
    logic [N_IN-1:0]  r_fix;
    logic [N_IN-1:0]  r_sub;
    logic [N_IN-1:0]  r_formula_in;
    logic [N_IN-1:0]  r_cex;
    logic [CNT_W-1:0] r_iters;
    logic             r_found;
    logic             r_aborted;
    logic             r_done;
    logic [N_IN-1:0]  w_sub_next;
    logic             w_exhausted;
    logic             w_accept;

    // Setting the non-free bits to 1 makes the carry ripple straight through them,
    // so the increment steps to the next sub-mask in ascending order.
    assign w_sub_next  = ((r_sub | ~r_mask) + {{(N_IN-1){1'b0}}, 1'b1}) & r_mask;
    assign w_exhausted = (r_sub == r_mask);
    assign w_accept    = start && (r_state != S_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (abort || !formula_out || w_exhausted) begin
                    w_state_next = S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_RUN);
        done = r_done;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask       <= '0;
            r_fix        <= '0;
            r_sub        <= '0;
            r_formula_in <= '0;
            r_cex        <= '0;
            r_iters      <= '0;
            r_found      <= 1'b0;
            r_aborted    <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_mask       <= free_mask;
                r_fix        <= fixed_val & ~free_mask;
                r_sub        <= '0;
                r_formula_in <= fixed_val & ~free_mask;
                r_cex        <= '0;
                r_iters      <= '0;
                r_found      <= 1'b0;
                r_aborted    <= 1'b0;
            end else if (r_state == S_RUN) begin
                if (r_iters != '1) begin
                    r_iters <= r_iters + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                if (abort) begin
                    r_aborted <= 1'b1;
                    r_found   <= 1'b0;
                    r_done    <= 1'b1;
                end else if (!formula_out) begin
                    r_found <= 1'b1;
                    r_cex   <= r_formula_in;
                    r_done  <= 1'b1;
                end else if (w_exhausted) begin
                    r_done <= 1'b1;
                end else begin
                    r_sub        <= w_sub_next;
                    r_formula_in <= r_fix | w_sub_next;
                end
            end
        end
    end

    assign formula_in = r_formula_in;
    assign found      = r_found;
    assign aborted    = r_aborted;
    assign cex        = r_cex;
    assign iters      = r_iters;

endmodule
